// File: rtl/ysyx_22050550_div_pkg.sv
// Shared widths, iteration counts, FSM encoding and helpers for the iterative divider.
`default_nettype none

package ysyx_22050550_div_pkg;

    localparam int XLEN    = 64;
    localparam int WLEN    = 32;
    localparam int N_DWORD = 64;
    localparam int N_WORD  = 32;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        VALID = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    // Word ops always report 32-bit results sign-extended to XLEN.
    function automatic logic [XLEN-1:0] fit_width(input logic word, input logic [XLEN-1:0] v);
        return word ? sext_word(v[WLEN-1:0]) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050550_DivStep.sv
// Single combinational restoring-division step: shift in one dividend bit, trial subtract.
`default_nettype none

module ysyx_22050550_DivStep
    import ysyx_22050550_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    // One extra bit keeps the compare exact when the divisor exceeds 2^(XLEN-1).
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, next_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/ysyx_22050550_div.sv
// Iterative radix-2 restoring divider (RV64M DIV/REM family); optional early exit via
// YSYX_22050550_DIV_EARLY_EXIT_EN.
`default_nettype none

module ysyx_22050550_div
    import ysyx_22050550_div_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            io_Exu_DivValid,
    input  logic            io_Exu_Flush,
    input  logic            io_Exu_Divw,
    input  logic            io_Exu_DivSigned,
    input  logic [XLEN-1:0] io_Exu_Dividend,
    input  logic [XLEN-1:0] io_Exu_Divisor,
    output logic            io_Exu_DivReady,
    output logic            io_Exu_OutValid,
    output logic [XLEN-1:0] io_Exu_Quotient,
    output logic [XLEN-1:0] io_Exu_Remainder
);

    div_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   dvd_sh, dsr_mag, rem_acc, quo_acc;
    logic [XLEN-1:0]   quotient_q, remainder_q;
    logic              neg_q, neg_r, is_word;

    logic [XLEN-1:0]   a_eff, b_eff, a_mag, b_mag;
    logic              a_neg, b_neg, b_zero, ovf, early, special, accept;
    logic [XLEN-1:0]   special_q, special_r;

    logic [XLEN-1:0]   rem_next, quo_last, quo_fix, rem_fix;
    logic              q_bit;

    assign a_eff = io_Exu_Divw ? (io_Exu_DivSigned ? sext_word(io_Exu_Dividend[WLEN-1:0])
                                                   : {{(XLEN-WLEN){1'b0}}, io_Exu_Dividend[WLEN-1:0]})
                               : io_Exu_Dividend;
    assign b_eff = io_Exu_Divw ? (io_Exu_DivSigned ? sext_word(io_Exu_Divisor[WLEN-1:0])
                                                   : {{(XLEN-WLEN){1'b0}}, io_Exu_Divisor[WLEN-1:0]})
                               : io_Exu_Divisor;

    assign a_neg  = io_Exu_DivSigned & a_eff[XLEN-1];
    assign b_neg  = io_Exu_DivSigned & b_eff[XLEN-1];
    assign a_mag  = a_neg ? (~a_eff + 1'b1) : a_eff;
    assign b_mag  = b_neg ? (~b_eff + 1'b1) : b_eff;
    assign b_zero = (b_eff == '0);

    assign ovf = io_Exu_DivSigned & (io_Exu_Divw
               ? ((io_Exu_Dividend[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}}) && (&io_Exu_Divisor[WLEN-1:0]))
               : ((io_Exu_Dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&io_Exu_Divisor)));

`ifdef YSYX_22050550_DIV_EARLY_EXIT_EN
    assign early = !b_zero && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    assign special   = b_zero | ovf | early;
    assign special_q = b_zero ? {XLEN{1'b1}} : (ovf ? fit_width(io_Exu_Divw, a_eff) : '0);
    assign special_r = ovf ? '0 : fit_width(io_Exu_Divw, a_eff);
    assign accept    = (state == IDLE) && io_Exu_DivValid;

    ysyx_22050550_DivStep u_step (
        .rem      (rem_acc),
        .next_bit (dvd_sh[XLEN-1]),
        .divisor  (dsr_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_last = {quo_acc[XLEN-2:0], q_bit};
    assign quo_fix  = fit_width(is_word, neg_q ? (~quo_last + 1'b1) : quo_last);
    assign rem_fix  = fit_width(is_word, neg_r ? (~rem_next + 1'b1) : rem_next);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io_Exu_DivValid) state_next = special ? VALID : BUSY;
            BUSY:    if (io_Exu_Flush) state_next = IDLE;
                     else if (cnt == '0) state_next = VALID;
            VALID:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            dvd_sh      <= '0;
            dsr_mag     <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            is_word     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            is_word <= io_Exu_Divw;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            // Left-justify word dividends so the step always consumes the MSB.
            dvd_sh  <= io_Exu_Divw ? {a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag;
            dsr_mag <= b_mag;
            rem_acc <= '0;
            quo_acc <= '0;
            cnt     <= io_Exu_Divw ? CNT_W'(N_WORD - 1) : CNT_W'(N_DWORD - 1);
            if (special) begin
                quotient_q  <= special_q;
                remainder_q <= special_r;
            end
        end else if (state == BUSY && !io_Exu_Flush) begin
            rem_acc <= rem_next;
            quo_acc <= quo_last;
            dvd_sh  <= {dvd_sh[XLEN-2:0], 1'b0};
            cnt     <= cnt - 1'b1;
            if (cnt == '0) begin
                quotient_q  <= quo_fix;
                remainder_q <= rem_fix;
            end
        end
    end

    assign io_Exu_DivReady  = (state == IDLE);
    assign io_Exu_OutValid  = (state == VALID);
    assign io_Exu_Quotient  = quotient_q;
    assign io_Exu_Remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050550_div.sv
// Scoreboard bench for ysyx_22050550_div: directed vectors, decoupled monitor.
`default_nettype none

module tb_ysyx_22050550_div;

`ifdef YSYX_22050550_DIV_EARLY_EXIT_EN
    localparam int LAT_EE64 = 1;
    localparam int LAT_EE32 = 1;
`else
    localparam int LAT_EE64 = 65;
    localparam int LAT_EE32 = 33;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        div_valid = 1'b0, flush = 1'b0, divw = 1'b0, div_signed = 1'b0;
    logic [63:0] dividend = '0, divisor = '0;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    ysyx_22050550_div dut (
        .clock            (clock),
        .reset            (reset),
        .io_Exu_DivValid  (div_valid),
        .io_Exu_Flush     (flush),
        .io_Exu_Divw      (divw),
        .io_Exu_DivSigned (div_signed),
        .io_Exu_Dividend  (dividend),
        .io_Exu_Divisor   (divisor),
        .io_Exu_DivReady  (div_ready),
        .io_Exu_OutValid  (out_valid),
        .io_Exu_Quotient  (quotient),
        .io_Exu_Remainder (remainder)
    );

    always begin
        #5;
        if (clk_en) clock = ~clock;
    end

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [63:0] last_q = '0, last_r = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per OutValid pulse; DUT must stay not-ready while work is pending.
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_outvalid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_quotient"}, quotient, e.q);
                    check({e.name, "_remainder"}, remainder, e.r);
                    check({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                    check({e.name, "_ready_in_valid"}, {63'b0, div_ready}, 64'd0);
                end
            end else if (sb.size() > 0) begin
                check({sb[0].name, "_ready_busy"}, {63'b0, div_ready}, 64'd0);
            end
        end
    end

    task automatic send(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!div_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!div_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
        @(posedge clock);
        #1 div_valid = 1'b0;
    endtask

    task automatic issue(input string name, input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input int lat);
        exp_t e;
        send(w, s, a, b);
        e.q = eq; e.r = er; e.lat = lat; e.acc = cyc; e.name = name;
        sb.push_back(e);
        last_q = eq;
        last_r = er;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #1;
        check("reset_ready", {63'b0, div_ready}, 64'd1);
        check("reset_outvalid", {63'b0, out_valid}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        #20 reset = 1'b1;

        issue("divu_100_7",   0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
        issue("div_m20_3",    0, 1, -64'sd20, 64'd3, 64'hFFFFFFFFFFFFFFFA, 64'hFFFFFFFFFFFFFFFE, 65);
        issue("div_20_m3",    0, 1, 64'd20, -64'sd3, 64'hFFFFFFFFFFFFFFFA, 64'd2, 65);
        issue("divu_by0",     0, 0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd5, 1);
        issue("div_ovf",      0, 1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 64'd0, 1);
        issue("divw_m7_2",    1, 1, 64'hDEADBEEFFFFFFFF9, 64'h1234567800000002,
              64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 33);
        issue("divuw_max_2",  1, 0, 64'hAAAAAAAAFFFFFFFF, 64'h5555555500000002,
              64'h000000007FFFFFFF, 64'd1, 33);
        issue("divuw_min_3",  1, 0, 64'h0000000180000000, 64'd3, 64'h000000002AAAAAAA, 64'd2, 33);
        issue("divuw_sext",   1, 0, 64'h00000000FFFFFFFE, 64'd1, 64'hFFFFFFFFFFFFFFFE, 64'd0, 33);
        issue("divw_ovf",     1, 1, 64'h0000000080000000, 64'h00000000FFFFFFFF,
              64'hFFFFFFFF80000000, 64'd0, 1);
        issue("divw_by0",     1, 1, 64'h00000000FFFFFFF9, 64'h1234567800000000,
              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF9, 1);
        issue("divu_bigdsr",  0, 0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001,
              64'd1, 64'h7FFFFFFFFFFFFFFE, 65);
        issue("divu_small",   0, 0, 64'd3, 64'd7, 64'd0, 64'd3, LAT_EE64);
        issue("div_small_neg", 0, 1, -64'sd3, 64'd7, 64'd0, 64'hFFFFFFFFFFFFFFFD, LAT_EE64);
        issue("divuw_small",  1, 0, 64'hFFFF000000000005, 64'h0000FFFF00000009, 64'd0, 64'd5, LAT_EE32);
        drain();

        issue("b2b_first",    0, 0, 64'd1000, 64'd10, 64'd100, 64'd0, 65);
        issue("b2b_second",   0, 0, 64'h0000000123456789, 64'h10000, 64'h12345, 64'h6789, 65);
        drain();

        // Flush on the 10th busy cycle: results must not change and no strobe may follow.
        send(0, 0, 64'd999, 64'd3);
        repeat (9) @(posedge clock);
        @(negedge clock) flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        check("flush_ready", {63'b0, div_ready}, 64'd1);
        check("flush_outvalid", {63'b0, out_valid}, 64'd0);
        check("flush_quotient", quotient, last_q);
        check("flush_remainder", remainder, last_r);
        repeat (80) @(negedge clock);

        // Asynchronous reset with the clock stopped mid-division.
        send(0, 0, 64'd12345, 64'd11);
        repeat (5) @(posedge clock);
        @(negedge clock);
        clk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("areset_ready", {63'b0, div_ready}, 64'd1);
        check("areset_outvalid", {63'b0, out_valid}, 64'd0);
        check("areset_quotient", quotient, 64'd0);
        check("areset_remainder", remainder, 64'd0);
        #5 reset = 1'b1;
        #2 clk_en = 1'b1;

        issue("post_reset",   0, 1, -64'sd100, -64'sd7, 64'd14, 64'hFFFFFFFFFFFFFFFE, 65);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
